// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: rebuilds LSB-first WIDTH-bit words framed by sof,
// pulsing valid on each completed word and err when a frame is cut short by a new sof.
module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             din,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sr, sr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   dout_n;
  logic               valid_n, err_n;
  logic [WIDTH-1:0]   shifted;

  assign shifted = {din, sr[WIDTH-1:1]};
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      dout  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
      valid <= valid_n;
      err   <= err_n;
    end
  end

  // A sof seen mid-frame restarts framing with the sampled din as the new bit 0.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    dout_n  = dout;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (ce && sof) begin
          sr_n    = shifted;
          cnt_n   = CNT_W'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (ce) begin
          sr_n = shifted;
          if (sof) begin
            err_n = 1'b1;
            cnt_n = CNT_W'(1);
          end else if (cnt == CNT_W'(WIDTH - 1)) begin
            dout_n  = shifted;
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus random traffic,
// compared every cycle against a bit-queue model of the framing rules.
module tb_sipo_rx;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce  = 1'b0;
  logic             din = 1'b0;
  logic             sof = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             busy;
  logic             err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] exp_dout  = '0;
  logic             exp_valid = 1'b0;
  logic             exp_err   = 1'b0;
  logic             in_frame  = 1'b0;
  bit               frame[$];

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .din  (din),
    .sof  (sof),
    .dout (dout),
    .valid(valid),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic s, input logic d);
    @(negedge clk);
    rst = r;
    ce  = c;
    sof = s;
    din = d;
  endtask

  // Sends a whole word with sof on bit 0; two ce-low cycles with noisy din follow bit stall_after.
  task automatic sendWord(input logic [WIDTH-1:0] w, input int stall_after);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 0), w[i]);
      if (i == stall_after) begin
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  // Reference model: collect sampled bits per frame, assemble the word once WIDTH bits arrive.
  always @(posedge clk) begin
    logic [WIDTH-1:0] word;
    if (rst) begin
      frame.delete();
      in_frame  = 1'b0;
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (ce) begin
        if (sof) begin
          if (in_frame) exp_err = 1'b1;
          frame.delete();
          frame.push_back(din);
          in_frame = 1'b1;
        end else if (in_frame) begin
          frame.push_back(din);
          if (frame.size() == WIDTH) begin
            word = '0;
            for (int i = 0; i < WIDTH; i++) word[i] = frame[i];
            exp_dout  = word;
            exp_valid = 1'b1;
            in_frame  = 1'b0;
            frame.delete();
          end
        end
      end
    end
    #1;
    checkOutput("dout",  32'(dout),  32'(exp_dout));
    checkOutput("valid", 32'(valid), 32'(exp_valid));
    checkOutput("err",   32'(err),   32'(exp_err));
    checkOutput("busy",  32'(busy),  32'(in_frame));
  end

  initial begin
    // Basic frame after a reset cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendWord(4'b0111, -1);
    @(posedge clk); #2;
    checkOutput("basic_dout",  32'(dout),  32'h7);
    checkOutput("basic_valid", 32'(valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("basic_valid_drop", 32'(valid), 32'h0);

    // ce stall between bits 1 and 2
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendWord(4'b0111, 1);
    @(posedge clk); #2;
    checkOutput("stall_dout",  32'(dout),  32'h7);
    checkOutput("stall_valid", 32'(valid), 32'h1);

    // Back-to-back frames
    sendWord(4'b1010, -1);
    sendWord(4'b0101, -1);
    @(posedge clk); #2;
    checkOutput("b2b_dout",  32'(dout),  32'h5);
    checkOutput("b2b_valid", 32'(valid), 32'h1);

    // Abort after two bits, then a full frame
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    checkOutput("abort_err",  32'(err),  32'h1);
    checkOutput("abort_dout", 32'(dout), 32'h5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    checkOutput("abort_dout_new", 32'(dout),  32'hC);
    checkOutput("abort_valid",    32'(valid), 32'h1);

    // Reset mid-frame
    sendWord(4'b0111, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    sendWord(4'b1001, -1);
    @(posedge clk); #2;
    checkOutput("post_rst_dout", 32'(dout), 32'h9);

    // Idle noise without sof
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'(i % 2));
    @(posedge clk); #2;
    checkOutput("noise_dout", 32'(dout), 32'h9);
    checkOutput("noise_busy", 32'(busy), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
